// File: rtl/iob_arbiter_pkg.sv
// Shared constants for the IOb arbiter: FSM encodings and the grant-index width helper.
// Optional feature macro used by the arbiter files: IOB_ARBITER_FIXED_PRIO_EN.
package iob_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_RWAIT = 2'd2;

  function automatic int grant_width(input int n_masters);
    return (n_masters > 1) ? $clog2(n_masters) : 1;
  endfunction

endpackage

// File: rtl/iob_arbiter_sel.sv
// Combinational winner select for the IOb arbiter: round-robin from last winner by default,
// lowest-index-wins when IOB_ARBITER_FIXED_PRIO_EN is defined.
module iob_arbiter_sel
  import iob_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int GRANT_W   = grant_width(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req_i,
`ifndef IOB_ARBITER_FIXED_PRIO_EN
  input  logic [GRANT_W-1:0]   last_i,
`endif
  output logic [GRANT_W-1:0]   winner_o,
  output logic                 any_o
);

`ifdef IOB_ARBITER_FIXED_PRIO_EN
  // Scan downwards so the lowest-index requester is written last and wins.
  always_comb begin
    winner_o = '0;
    any_o    = |req_i;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        winner_o = GRANT_W'(i);
      end
    end
  end
`else
  logic found;
  int   idx;

  // Search starts just after the previous winner and wraps around.
  always_comb begin
    winner_o = '0;
    any_o    = |req_i;
    found    = 1'b0;
    idx      = 0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      idx = (int'(last_i) + i) % N_MASTERS;
      if (!found && req_i[idx]) begin
        winner_o = GRANT_W'(idx);
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/iob_arbiter.sv
// Shares one IOb slave among N_MASTERS IOb masters, one transaction per grant.
// Define IOB_ARBITER_FIXED_PRIO_EN for fixed priority instead of round-robin.
module iob_arbiter
  import iob_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                          clk_i,
  input  logic                          cke_i,
  input  logic                          rst_i,
  input  logic [N_MASTERS-1:0]          m_avalid_i,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr_i,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata_i,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb_i,
  output logic [N_MASTERS*DATA_W-1:0]   m_rdata_o,
  output logic [N_MASTERS-1:0]          m_rvalid_o,
  output logic [N_MASTERS-1:0]          m_ready_o,
  output logic                          s_avalid_o,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic [DATA_W-1:0]             s_wdata_o,
  output logic [DATA_W/8-1:0]           s_wstrb_o,
  input  logic [DATA_W-1:0]             s_rdata_i,
  input  logic                          s_rvalid_i,
  input  logic                          s_ready_i
);

  localparam int GRANT_W = grant_width(N_MASTERS);
  localparam int STRB_W  = DATA_W / 8;

  logic [1:0]         state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] winner;
  logic               any_req;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [STRB_W-1:0]  sel_wstrb;
  logic               in_req;
  logic               in_rwait;

`ifndef IOB_ARBITER_FIXED_PRIO_EN
  logic [GRANT_W-1:0] last_q, last_d;
`endif

  iob_arbiter_sel #(
    .N_MASTERS (N_MASTERS),
    .GRANT_W   (GRANT_W)
  ) u_sel (
    .req_i    (m_avalid_i),
`ifndef IOB_ARBITER_FIXED_PRIO_EN
    .last_i   (last_q),
`endif
    .winner_o (winner),
    .any_o    (any_req)
  );

  assign in_req   = (state_q == ST_REQ);
  assign in_rwait = (state_q == ST_RWAIT);

  // Slave-side request comes from the owner only while the request phase is open.
  always_comb begin
    sel_addr   = m_addr_i[int'(grant_q)*ADDR_W +: ADDR_W];
    sel_wdata  = m_wdata_i[int'(grant_q)*DATA_W +: DATA_W];
    sel_wstrb  = m_wstrb_i[int'(grant_q)*STRB_W +: STRB_W];
    s_avalid_o = in_req;
    s_addr_o   = in_req ? sel_addr  : '0;
    s_wdata_o  = in_req ? sel_wdata : '0;
    s_wstrb_o  = in_req ? sel_wstrb : '0;
    m_ready_o  = '0;
    m_rvalid_o = '0;
    if (in_req) begin
      m_ready_o[grant_q] = s_ready_i;
    end
    if (in_rwait) begin
      m_rvalid_o[grant_q] = s_rvalid_i;
    end
    m_rdata_o  = {N_MASTERS{s_rdata_i}};
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d = winner;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (s_ready_i) begin
          state_d = (|sel_wstrb) ? ST_IDLE : ST_RWAIT;
        end
      end
      ST_RWAIT: begin
        if (s_rvalid_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifndef IOB_ARBITER_FIXED_PRIO_EN
  always_comb begin
    last_d = last_q;
    if (state_q == ST_IDLE && any_req) begin
      last_d = winner;
    end
  end
`endif

  // Reset wins over the clock enable so a stalled bus can still be recovered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
`ifndef IOB_ARBITER_FIXED_PRIO_EN
      last_q  <= GRANT_W'(N_MASTERS - 1);
`endif
    end else if (cke_i) begin
      state_q <= state_d;
      grant_q <= grant_d;
`ifndef IOB_ARBITER_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_iob_arbiter.sv
// Self-checking bench for iob_arbiter with four masters against a transaction-level model.
// Honours IOB_ARBITER_FIXED_PRIO_EN when predicting winners.
module tb_iob_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic            cke;
   logic            rst;
   logic [N-1:0]    mAvalid;
   logic [N*AW-1:0] mAddrBus;
   logic [N*DW-1:0] mWdataBus;
   logic [N*SW-1:0] mWstrbBus;
   logic [N*DW-1:0] mRdata;
   logic [N-1:0]    mRvalid;
   logic [N-1:0]    mReady;
   logic            sAvalid;
   logic [AW-1:0]   sAddr;
   logic [DW-1:0]   sWdata;
   logic [SW-1:0]   sWstrb;
   logic [DW-1:0]   sRdata;
   logic            sRvalid;
   logic            sReady;

   iob_arbiter #(
      .N_MASTERS (N),
      .ADDR_W    (AW),
      .DATA_W    (DW)
   ) dut (
      .clk_i      (clock),
      .cke_i      (cke),
      .rst_i      (rst),
      .m_avalid_i (mAvalid),
      .m_addr_i   (mAddrBus),
      .m_wdata_i  (mWdataBus),
      .m_wstrb_i  (mWstrbBus),
      .m_rdata_o  (mRdata),
      .m_rvalid_o (mRvalid),
      .m_ready_o  (mReady),
      .s_avalid_o (sAvalid),
      .s_addr_o   (sAddr),
      .s_wdata_o  (sWdata),
      .s_wstrb_o  (sWstrb),
      .s_rdata_i  (sRdata),
      .s_rvalid_i (sRvalid),
      .s_ready_i  (sReady)
   );

   // Per-master pending transaction, held until the arbiter accepts it
   bit          mActive [N];
   logic [31:0] mAddr   [N];
   logic [31:0] mData   [N];
   logic [3:0]  mStrb   [N];

   // Model: owner = -1 means the slave is free; awaiting = read accepted, data outstanding
   int owner;
   bit awaiting;
   int lastWinner;
   int served [$];

   int checkCount;
   int passCount;

   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checkCount++;
      if (got === exp) passCount++;
      else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic newRequest(input int k, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      mActive[k] = 1'b1;
      mAddr[k]   = addr;
      mData[k]   = data;
      mStrb[k]   = strb;
   endtask

   function automatic int pickWinner();
      int c;
`ifdef IOB_ARBITER_FIXED_PRIO_EN
      for (int i = 0; i < N; i++) if (mActive[i]) return i;
`else
      for (int i = 1; i <= N; i++) begin
         c = (lastWinner + i) % N;
         if (mActive[c]) return c;
      end
`endif
      return -1;
   endfunction

   // One clock cycle: drive inputs, check outputs against the model, then advance the model
   task automatic applyStimulus(input bit doReset, input bit clkEn, input bit slvReady,
                                input bit slvRvalid, input logic [31:0] slvData);
      logic [N-1:0] expReady;
      logic [N-1:0] expRvalid;
      logic [31:0]  expAddr;
      logic [31:0]  expData;
      logic [3:0]   expStrb;
      bit           reqPhase;
      int           w;
      @(negedge clock);
      rst     = doReset;
      cke     = clkEn;
      sReady  = slvReady;
      sRvalid = slvRvalid;
      sRdata  = slvData;
      for (int k = 0; k < N; k++) begin
         mAvalid[k]              = mActive[k];
         mAddrBus[k*AW +: AW]    = mAddr[k];
         mWdataBus[k*DW +: DW]   = mData[k];
         mWstrbBus[k*SW +: SW]   = mStrb[k];
      end
      #1;
      reqPhase  = (owner >= 0) && !awaiting;
      expReady  = '0;
      expRvalid = '0;
      expAddr   = '0;
      expData   = '0;
      expStrb   = '0;
      if (reqPhase) begin
         expAddr = mAddr[owner];
         expData = mData[owner];
         expStrb = mStrb[owner];
         if (slvReady) expReady[owner] = 1'b1;
      end
      if (owner >= 0 && awaiting && slvRvalid) expRvalid[owner] = 1'b1;
      checkOutput("s_avalid", sAvalid, reqPhase);
      checkOutput("s_addr", sAddr, expAddr);
      checkOutput("s_wdata", sWdata, expData);
      checkOutput("s_wstrb", sWstrb, expStrb);
      checkOutput("m_ready", mReady, expReady);
      checkOutput("m_rvalid", mRvalid, expRvalid);
      checkOutput("m_rdata", mRdata, {N{slvData}});
      if (clkEn && !doReset)
         for (int k = 0; k < N; k++) if (mReady[k] === 1'b1) served.push_back(k);
      @(posedge clock);
      if (doReset) begin
         owner      = -1;
         awaiting   = 1'b0;
         lastWinner = N - 1;
      end else if (clkEn) begin
         if (owner < 0) begin
            w = pickWinner();
            if (w >= 0) begin
               owner      = w;
               lastWinner = w;
            end
         end else if (!awaiting) begin
            if (slvReady) begin
               mActive[owner] = 1'b0;
               if (mStrb[owner] != 4'd0) owner = -1;
               else awaiting = 1'b1;
            end
         end else if (slvRvalid) begin
            owner    = -1;
            awaiting = 1'b0;
         end
      end
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      owner      = -1;
      awaiting   = 1'b0;
      lastWinner = N - 1;
      for (int k = 0; k < N; k++) begin
         mActive[k] = 1'b0;
         mAddr[k]   = '0;
         mData[k]   = '0;
         mStrb[k]   = '0;
      end
      rst = 1'b1; cke = 1'b1; sReady = 1'b0; sRvalid = 1'b0; sRdata = '0;
      mAvalid = '0; mAddrBus = '0; mWdataBus = '0; mWstrbBus = '0;
      repeat (2) @(posedge clock);

      // Reset state, then a single write from master 1
      applyStimulus(1, 1, 0, 0, 32'h0);
      applyStimulus(0, 1, 0, 0, 32'h5A5A);
      newRequest(1, 32'h10, 32'hCAFE, 4'hF);
      repeat (3) applyStimulus(0, 1, 1, 0, 32'h0);

      // Read from master 0 with three cycles of data latency
      newRequest(0, 32'h20, 32'h0, 4'h0);
      repeat (2) applyStimulus(0, 1, 1, 0, 32'h0);
      repeat (2) applyStimulus(0, 1, 0, 0, 32'h0);
      applyStimulus(0, 1, 0, 1, 32'h1234);
      applyStimulus(0, 1, 0, 0, 32'h0);

      // All masters write back to back from a fresh reset
      applyStimulus(1, 1, 0, 0, 32'h0);
      served.delete();
      for (int c = 0; c < 12; c++) begin
         for (int k = 0; k < N; k++)
            if (!mActive[k]) newRequest(k, 32'h100 + k, 32'hD000 + k, 4'h3);
         applyStimulus(0, 1, 1, 0, $urandom);
      end
      checkOutput("order_len", served.size(), 6);
      for (int i = 0; i < served.size() && i < 6; i++) begin
`ifdef IOB_ARBITER_FIXED_PRIO_EN
         checkOutput("order", served[i], 0);
`else
         checkOutput("order", served[i], i % N);
`endif
      end

      // Backpressure with two competing writers
      applyStimulus(1, 1, 0, 0, 32'h0);
      for (int k = 0; k < N; k++) mActive[k] = 1'b0;
      newRequest(1, 32'hAAA0, 32'h1111, 4'h1);
      newRequest(2, 32'hBBB0, 32'h2222, 4'h8);
      applyStimulus(0, 1, 0, 0, 32'h0);
      repeat (5) applyStimulus(0, 1, 0, 0, 32'h0);
      repeat (4) applyStimulus(0, 1, 1, 0, 32'h0);

      // Reset while a read is outstanding, then a late response
      for (int k = 0; k < N; k++) mActive[k] = 1'b0;
      newRequest(0, 32'h40, 32'h0, 4'h0);
      repeat (2) applyStimulus(0, 1, 1, 0, 32'h0);
      applyStimulus(0, 1, 0, 0, 32'h0);
      applyStimulus(1, 1, 0, 0, 32'h0);
      applyStimulus(0, 1, 0, 1, 32'hBEEF);
      newRequest(0, 32'h44, 32'h77, 4'hF);
      newRequest(3, 32'h48, 32'h88, 4'hF);
      repeat (3) applyStimulus(0, 1, 1, 0, 32'h0);
      checkOutput("post_reset_winner", served[served.size()-1], 0);

      // Randomized traffic with clock-enable gaps and occasional resets
      for (int c = 0; c < 2000; c++) begin
         for (int k = 0; k < N; k++)
            if (!mActive[k] && $urandom_range(0, 9) < 3)
               newRequest(k, $urandom, $urandom,
                          ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0);
         applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
                       $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3, $urandom);
      end

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
